// File: rtl/mem_arbiter_if.sv
// ============================================================================
// Module  : mem_arbiter_if
// Brief   : Requester-port and memory_bus signal bundle for mem_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_arbiter_if;
   logic        req_0;
   logic        req_1;
   logic        write_0;
   logic        write_1;
   logic [15:0] addr_0;
   logic [15:0] addr_1;
   logic [31:0] wdata_0;
   logic [31:0] wdata_1;
   logic [3:0]  wmask_0;
   logic [3:0]  wmask_1;
   logic        lock_0;
   logic        lock_1;
   logic        ack_0;
   logic        ack_1;
   logic [31:0] rdata;
   logic        grant;
   logic        busy;
   logic [15:0] mem_address;
   logic [31:0] mem_write;
   logic [3:0]  mem_write_mask;
   logic        mem_bus_enable;
   logic        mem_write_enable;
   logic [31:0] mem_read;

   modport slave (
      input  req_0, req_1, write_0, write_1, addr_0, addr_1,
             wdata_0, wdata_1, wmask_0, wmask_1, lock_0, lock_1, mem_read,
      output ack_0, ack_1, rdata, grant, busy,
             mem_address, mem_write, mem_write_mask, mem_bus_enable, mem_write_enable
   );

   modport master (
      output req_0, req_1, write_0, write_1, addr_0, addr_1,
             wdata_0, wdata_1, wmask_0, wmask_1, lock_0, lock_1, mem_read,
      input  ack_0, ack_1, rdata, grant, busy,
             mem_address, mem_write, mem_write_mask, mem_bus_enable, mem_write_enable
   );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module  : mem_arbiter
// Brief   : Two-port round-robin arbiter/sequencer for memory_bus.
//           Optional grant locking when ARB_LOCK_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
   parameter int LATENCY = 1
) (
   input  wire logic     clk,
   input  wire logic     reset,
   mem_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [2:0] c_wait_load = 3'(LATENCY - 1);

   state_t      r_state;
   logic [2:0]  r_wait_cnt;
   logic        r_last_grant;
   logic        r_grant;
   logic        r_write;
   logic        r_ack_0;
   logic        r_ack_1;
   logic        r_busy;
   logic [31:0] r_rdata;
   logic [15:0] r_mem_address;
   logic [31:0] r_mem_write;
   logic [3:0]  r_mem_write_mask;
   logic        r_mem_bus_enable;
   logic        r_mem_write_enable;
   logic        w_req_any;
   logic        w_sel;

`ifdef ARB_LOCK_EN
   logic        r_locked;

   // A locked owner is the only port IDLE will consider.
   always_comb begin
      w_req_any = 1'b0;
      w_sel     = 1'b0;
      if (r_locked) begin
         w_sel     = r_grant;
         w_req_any = r_grant ? bus.req_1 : bus.req_0;
      end else begin
         w_req_any = bus.req_0 | bus.req_1;
         if (bus.req_0 && bus.req_1) w_sel = ~r_last_grant;
         else                        w_sel = bus.req_1;
      end
   end
`else
   logic        w_unused_lock;
   assign w_unused_lock = bus.lock_0 ^ bus.lock_1;

   always_comb begin
      w_req_any = bus.req_0 | bus.req_1;
      w_sel     = 1'b0;
      if (bus.req_0 && bus.req_1) w_sel = ~r_last_grant;
      else                        w_sel = bus.req_1;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state            <= S_IDLE;
         r_wait_cnt         <= 3'd0;
         r_last_grant       <= 1'b1;
         r_grant            <= 1'b0;
         r_write            <= 1'b0;
         r_ack_0            <= 1'b0;
         r_ack_1            <= 1'b0;
         r_busy             <= 1'b0;
         r_rdata            <= 32'd0;
         r_mem_address      <= 16'd0;
         r_mem_write        <= 32'd0;
         r_mem_write_mask   <= 4'd0;
         r_mem_bus_enable   <= 1'b0;
         r_mem_write_enable <= 1'b0;
`ifdef ARB_LOCK_EN
         r_locked           <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_req_any) begin
                  r_grant            <= w_sel;
`ifndef ARB_LOCK_EN
                  r_last_grant       <= w_sel;
`endif
                  r_mem_address      <= w_sel ? bus.addr_1  : bus.addr_0;
                  r_mem_write        <= w_sel ? bus.wdata_1 : bus.wdata_0;
                  r_mem_write_mask   <= w_sel ? bus.wmask_1 : bus.wmask_0;
                  r_write            <= w_sel ? bus.write_1 : bus.write_0;
                  r_mem_write_enable <= w_sel ? bus.write_1 : bus.write_0;
                  r_mem_bus_enable   <= 1'b1;
                  r_busy             <= 1'b1;
                  r_state            <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_mem_bus_enable <= 1'b0;
               r_wait_cnt       <= c_wait_load;
               r_state          <= S_WAIT;
            end
            S_WAIT: begin
               if (r_wait_cnt == 3'd0) begin
                  if (!r_write) r_rdata <= bus.mem_read;
                  r_mem_write_enable <= 1'b0;
                  r_ack_0            <= ~r_grant;
                  r_ack_1            <= r_grant;
                  r_state            <= S_DONE;
               end else begin
                  r_wait_cnt <= r_wait_cnt - 3'd1;
               end
            end
            S_DONE: begin
               r_ack_0 <= 1'b0;
               r_ack_1 <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
`ifdef ARB_LOCK_EN
               if (r_grant ? bus.lock_1 : bus.lock_0) begin
                  r_locked <= 1'b1;
               end else begin
                  r_locked     <= 1'b0;
                  r_last_grant <= r_grant;
               end
`endif
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.ack_0            = r_ack_0;
   assign bus.ack_1            = r_ack_1;
   assign bus.rdata            = r_rdata;
   assign bus.grant            = r_grant;
   assign bus.busy             = r_busy;
   assign bus.mem_address      = r_mem_address;
   assign bus.mem_write        = r_mem_write;
   assign bus.mem_write_mask   = r_mem_write_mask;
   assign bus.mem_bus_enable   = r_mem_bus_enable;
   assign bus.mem_write_enable = r_mem_write_enable;

endmodule

`default_nettype wire
